// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem and presents
// the IF/ID pair to the decoder, with bubble insertion and fetch/bubble counters.
module ama_riscv_fetch #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          IMEM_AW    = 14,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pc_sel,
    input  logic               pc_we,
    input  logic               stall_if,
    input  logic               clear_if,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        bp_target,
    input  logic [31:0]        imem_rdata,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_en,
    output logic [31:0]        pc_id,
    output logic [31:0]        inst_id,
    output logic               inst_valid_id,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt
);

    typedef enum logic [1:0] {
        PC_START = 2'd0,
        PC_INC4  = 2'd1,
        PC_ALU   = 2'd2,
        PC_BP    = 2'd3
    } pc_sel_e;

    logic [31:0] pc_q, pc_d;
    logic        rst_bubble_q;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        kill;

    always_comb begin
        pc_d = pc_q;
        if (rst) begin
            pc_d = START_ADDR;
        end else if (stall_if || !pc_we) begin
            pc_d = pc_q;
        end else begin
            case (pc_sel_e'(pc_sel))
                PC_START: pc_d = START_ADDR;
                PC_INC4:  pc_d = pc_q + 32'd4;
                PC_ALU:   pc_d = {alu_out[31:2], 2'b00};
                PC_BP:    pc_d = {bp_target[31:2], 2'b00};
                default:  pc_d = pc_q;
            endcase
        end
    end

    // The imem is addressed with next PC so its registered data lines up with pc_q.
    assign imem_addr = pc_d[IMEM_AW+1:2];
    assign imem_en   = 1'b1;

    assign kill          = rst_bubble_q | clear_if | rst;
    assign pc_id         = pc_q;
    assign inst_id       = kill ? NOP : imem_rdata;
    assign inst_valid_id = !kill;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (rst) begin
            fetch_cnt_d  = 32'd0;
            bubble_cnt_d = 32'd0;
        end else begin
            if (inst_valid_id && !stall_if) fetch_cnt_d  = fetch_cnt_q + 32'd1;
            if (!inst_valid_id)             bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        rst_bubble_q <= rst;
        fetch_cnt_q  <= fetch_cnt_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
